// File: rtl/vram_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module      : vram_arbiter_if
// Description : Video, CPU and VRAM-side signal bundle for vram_arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
interface vram_arbiter_if;
  logic        ce;
  logic        vidActive;
  logic        vidReq;
  logic [1:0]  vidB;
  logic [12:0] vidA;
  logic [7:0]  vidD;
  logic        cpuReq;
  logic        cpuWr;
  logic [1:0]  cpuB;
  logic [12:0] cpuA;
  logic [7:0]  cpuD;
  logic [7:0]  cpuQ;
  logic        cpuWait;
  logic [14:0] memA;
  logic [7:0]  memD;
  logic        memWe;
  logic [7:0]  memQ;
  logic [1:0]  grant;

  modport slave (
    input  ce, vidActive, vidReq, vidB, vidA,
    input  cpuReq, cpuWr, cpuB, cpuA, cpuD,
    input  memQ,
    output vidD, cpuQ, cpuWait, memA, memD, memWe, grant
  );

  modport master (
    output ce, vidActive, vidReq, vidB, vidA,
    output cpuReq, cpuWr, cpuB, cpuA, cpuD,
    output memQ,
    input  vidD, cpuQ, cpuWait, memA, memD, memWe, grant
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module      : vram_arbiter
// Description : Slot arbiter sharing the 32 KB VRAM between video fetch and CPU.
//               Optional macro VRAM_CONTENTION_EN blocks the CPU for the whole
//               active display window.
// Revision    : 1.0 - initial release
// =============================================================================
module vram_arbiter (
  input  logic          clock,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_VID  = 2'b01;
  localparam logic [1:0] GRANT_CPU  = 2'b10;

  state_t      state;
  state_t      state_next;
  logic        cpu_allowed;
  logic        cpu_grant;
  logic        acc_wr;
  logic        mem_we;
  logic [14:0] mem_a;
  logic [7:0]  mem_d;
  logic [7:0]  cpu_q;
  logic [1:0]  grant;

`ifdef VRAM_CONTENTION_EN
  assign cpu_allowed = ~bus.vidActive;
`else
  // vidActive only shapes arbitration in the contention build
  logic unused_vid_active;
  assign unused_vid_active = bus.vidActive;
  assign cpu_allowed       = 1'b1;
`endif

  assign cpu_grant = bus.ce & ~bus.vidReq & cpu_allowed & bus.cpuReq &
                     ((state == IDLE) | (state == WAIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.cpuReq) state_next = cpu_grant ? ACCESS : WAIT;
      WAIT: begin
        if (cpu_grant)        state_next = ACCESS;
        else if (!bus.cpuReq) state_next = IDLE;
      end
      // A request dropped here still completes; the slot is already committed
      ACCESS:  if (bus.ce) state_next = DONE;
      DONE:    if (!bus.cpuReq) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_a  <= '0;
      mem_d  <= '0;
      mem_we <= 1'b0;
      cpu_q  <= '0;
      grant  <= GRANT_NONE;
      acc_wr <= 1'b0;
    end else begin
      mem_we <= cpu_grant & bus.cpuWr;
      if (bus.ce) begin
        if (bus.vidReq) begin
          grant <= GRANT_VID;
          mem_a <= {bus.vidB, bus.vidA};
        end else if (cpu_grant) begin
          grant  <= GRANT_CPU;
          mem_a  <= {bus.cpuB, bus.cpuA};
          mem_d  <= bus.cpuD;
          acc_wr <= bus.cpuWr;
        end else begin
          grant <= GRANT_NONE;
        end
        // memQ still reflects the CPU address latched one slot earlier
        if ((state == ACCESS) && !acc_wr) begin
          cpu_q <= bus.memQ;
        end
      end
    end
  end

  assign bus.memA    = mem_a;
  assign bus.memD    = mem_d;
  assign bus.memWe   = mem_we;
  assign bus.cpuQ    = cpu_q;
  assign bus.grant   = grant;
  assign bus.vidD    = bus.memQ;
  assign bus.cpuWait = bus.cpuReq & (state != DONE);

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module      : tb_vram_arbiter
// Description : Randomized self-checking bench for vram_arbiter against a
//               slot-level reference model; honours VRAM_CONTENTION_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vram_arbiter_if bus ();

  vram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // VRAM primitive: synchronous write, one-clock read latency
  bit [7:0] vram [32768];
  always @(posedge clock) begin
    if (bus.memWe) vram[bus.memA] <= bus.memD;
    bus.memQ <= vram[bus.memA];
  end

  // Reference model: who owns each slot, and where the CPU transaction stands
  // (0 = nothing issued, 1 = issued and due next boundary, 2 = delivered).
  bit [7:0]    ref_mem [32768];
  logic [1:0]  m_grant = 2'b00;
  logic [14:0] m_memA  = '0;
  logic [14:0] m_addr  = '0;
  logic [7:0]  m_memD  = '0;
  logic [7:0]  m_cpuQ  = '0;
  logic        m_memWe = 1'b0;
  logic        m_wr    = 1'b0;
  int          m_phase = 0;
  int          m_since = 0;
  logic        cpu_ok;

`ifdef VRAM_CONTENTION_EN
  assign cpu_ok = ~bus.vidActive;
`else
  assign cpu_ok = 1'b1;
`endif

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_grant <= 2'b00;
      m_memA  <= '0;
      m_memD  <= '0;
      m_memWe <= 1'b0;
      m_cpuQ  <= '0;
      m_phase <= 0;
      m_since <= 0;
    end else begin
      if (m_memWe) ref_mem[m_memA] <= m_memD;
      m_memWe <= 1'b0;
      m_since <= bus.ce ? 0 : m_since + 1;
      if (m_phase == 2 && !bus.cpuReq) m_phase <= 0;
      if (bus.ce) begin
        if (m_phase == 1) begin
          if (!m_wr) m_cpuQ <= ref_mem[m_addr];
          m_phase <= 2;
        end
        if (bus.vidReq) begin
          m_grant <= 2'b01;
          m_memA  <= {bus.vidB, bus.vidA};
        end else if (m_phase == 0 && bus.cpuReq && cpu_ok) begin
          m_grant <= 2'b10;
          m_memA  <= {bus.cpuB, bus.cpuA};
          m_addr  <= {bus.cpuB, bus.cpuA};
          m_memD  <= bus.cpuD;
          m_memWe <= bus.cpuWr;
          m_wr    <= bus.cpuWr;
          m_phase <= 1;
        end else begin
          m_grant <= 2'b00;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (chk_en) begin
        check("grant",   32'(bus.grant),   32'(m_grant));
        check("memA",    32'(bus.memA),    32'(m_memA));
        check("memD",    32'(bus.memD),    32'(m_memD));
        check("memWe",   32'(bus.memWe),   32'(m_memWe));
        check("cpuQ",    32'(bus.cpuQ),    32'(m_cpuQ));
        check("cpuWait", 32'(bus.cpuWait), 32'(bus.cpuReq & (m_phase != 2)));
        if (m_grant == 2'b01 && m_since >= 1)
          check("vidD", 32'(bus.vidD), 32'(ref_mem[m_memA]));
      end
    end
  end

  // Slot and video stimulus: 0 quiet, 1 random, 2 active window with vidReq
  // on alternate slots, 3 video holds the first three slots, 4 video always.
  int vid_mode = 0;
  bit gen_en   = 1'b0;
  initial begin
    int gap       = 0;
    int slot      = 0;
    int last_mode = -1;
    bus.ce = 1'b0; bus.vidActive = 1'b0; bus.vidReq = 1'b0; bus.vidB = '0; bus.vidA = '0;
    forever begin
      @(negedge clock);
      if (!gen_en) begin
        bus.ce = 1'b0;
      end else if (gap == 0) begin
        if (vid_mode != last_mode) begin
          slot      = 0;
          last_mode = vid_mode;
        end
        bus.ce   = 1'b1;
        gap      = $urandom_range(1, 3);
        bus.vidB = 2'($urandom);
        bus.vidA = 13'($urandom_range(0, 31));
        case (vid_mode)
          0: begin bus.vidActive = 1'b0; bus.vidReq = 1'b0; end
          1: begin
            if ($urandom_range(0, 7) == 0) bus.vidActive = ~bus.vidActive;
            bus.vidReq = 1'($urandom_range(0, 1));
          end
          2: begin bus.vidActive = (slot < 8); bus.vidReq = (slot < 8) && (slot % 2 == 0); end
          3: begin bus.vidActive = 1'b0; bus.vidReq = (slot < 3); end
          default: begin bus.vidActive = 1'b1; bus.vidReq = 1'b1; end
        endcase
        slot++;
      end else begin
        bus.ce = 1'b0;
        gap--;
      end
    end
  end

  // abort_after: 0 hold until served, >0 drop after that many clocks,
  // -1 drop in the clock the CPU grant becomes visible.
  task automatic cpu_op(input bit wr, input logic [1:0] b, input logic [12:0] a,
                        input logic [7:0] d, input int abort_after,
                        output bit granted, output int we_clks, output bit act_at_grant,
                        output logic [14:0] ga, output logic [7:0] gd);
    int n         = 0;
    bit done      = 1'b0;
    bit timed_out = 1'b0;
    granted = 1'b0; we_clks = 0; act_at_grant = 1'b0; ga = '0; gd = '0;
    @(negedge clock);
    bus.cpuReq = 1'b1; bus.cpuWr = wr; bus.cpuB = b; bus.cpuA = a; bus.cpuD = d;
    while (!done) begin
      @(negedge clock);
      n++;
      if (bus.memWe) we_clks++;
      if (bus.grant == 2'b10 && !granted) begin
        granted      = 1'b1;
        act_at_grant = bus.vidActive;
        ga           = bus.memA;
        gd           = bus.memD;
        if (abort_after < 0) done = 1'b1;
      end
      if (!bus.cpuWait) done = 1'b1;
      else if (abort_after > 0 && n >= abort_after) done = 1'b1;
      else if (n >= 400) begin timed_out = 1'b1; done = 1'b1; end
    end
    check("cpu_bounded", 32'(timed_out), 32'd0);
    bus.cpuReq = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (bus.memWe) we_clks++;
      if (bus.grant == 2'b10) granted = 1'b1;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g, act, exp_act, wr, stuck;
    int          we, ab, n;
    logic [14:0] ga;
    logic [7:0]  gd;
    logic [1:0]  b;
    logic [12:0] a;
    bus.cpuReq = 1'b0; bus.cpuWr = 1'b0; bus.cpuB = '0; bus.cpuA = '0; bus.cpuD = '0;

    repeat (3) @(negedge clock);
    #1;
    check("rst_grant",   32'(bus.grant),   32'd0);
    check("rst_memA",    32'(bus.memA),    32'd0);
    check("rst_memD",    32'(bus.memD),    32'd0);
    check("rst_memWe",   32'(bus.memWe),   32'd0);
    check("rst_cpuQ",    32'(bus.cpuQ),    32'd0);
    bus.cpuReq = 1'b1;
    #1 check("rst_cpuWait", 32'(bus.cpuWait), 32'(bus.cpuReq));
    bus.cpuReq = 1'b0;
    @(negedge clock);
    reset = 1'b1; chk_en = 1'b1; gen_en = 1'b1; vid_mode = 0;

    // Write then read back on an idle bus
    cpu_op(1'b1, 2'd2, 13'h0155, 8'hA5, 0, g, we, act, ga, gd);
    check("wr_granted", 32'(g),  32'd1);
    check("wr_memA",    32'(ga), 32'h4155);
    check("wr_memD",    32'(gd), 32'hA5);
    check("wr_we_clks", 32'(we), 32'd1);
    cpu_op(1'b0, 2'd2, 13'h0155, 8'h00, 0, g, we, act, ga, gd);
    check("rd_cpuQ",    32'(bus.cpuQ), 32'hA5);
    check("rd_we_clks", 32'(we),       32'd0);

    // Video claims the CPU's first boundaries
    @(posedge clock); vid_mode = 3;
    cpu_op(1'b0, 2'd1, 13'h0007, 8'h00, 0, g, we, act, ga, gd);
    check("prio_granted", 32'(g), 32'd1);

    // Active window with alternating video fetches
    @(posedge clock); vid_mode = 2;
    cpu_op(1'b1, 2'd3, 13'h1ABC, 8'h3C, 0, g, we, act, ga, gd);
`ifdef VRAM_CONTENTION_EN
    exp_act = 1'b0;
`else
    exp_act = 1'b1;
`endif
    check("window_act_at_grant", 32'(act), 32'(exp_act));
    check("window_we_clks",      32'(we),  32'd1);

    // Request withdrawn while waiting behind video
    @(posedge clock); vid_mode = 4;
    cpu_op(1'b1, 2'd0, 13'h0010, 8'h77, 8, g, we, act, ga, gd);
    check("abort_wait_granted", 32'(g),  32'd0);
    check("abort_wait_we",      32'(we), 32'd0);

    // Request withdrawn during the access still completes
    @(posedge clock); vid_mode = 0;
    cpu_op(1'b1, 2'd1, 13'h00AA, 8'h5A, 0, g, we, act, ga, gd);
    cpu_op(1'b0, 2'd1, 13'h00AA, 8'h00, -1, g, we, act, ga, gd);
    check("drop_access_cpuQ", 32'(bus.cpuQ), 32'h5A);

    // Reset in the middle of an access
    @(negedge clock);
    bus.cpuReq = 1'b1; bus.cpuWr = 1'b0; bus.cpuB = 2'd2; bus.cpuA = 13'h0155;
    n = 0; stuck = 1'b0;
    while (bus.grant != 2'b10 && !stuck) begin
      @(negedge clock);
      n++;
      if (n > 50) stuck = 1'b1;
    end
    check("rstmid_reached_grant", 32'(stuck), 32'd0);
    #3 reset = 1'b0;
    #1;
    check("rstmid_grant", 32'(bus.grant), 32'd0);
    check("rstmid_memA",  32'(bus.memA),  32'd0);
    check("rstmid_cpuQ",  32'(bus.cpuQ),  32'd0);
    check("rstmid_memWe", 32'(bus.memWe), 32'd0);
    bus.cpuReq = 1'b0;
    @(negedge clock); #3 reset = 1'b1;
    cpu_op(1'b0, 2'd2, 13'h0155, 8'h00, 0, g, we, act, ga, gd);
    check("rstmid_after_cpuQ", 32'(bus.cpuQ), 32'hA5);

    // Randomized traffic over a small address pool shared with video
    @(posedge clock); vid_mode = 1;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      b  = 2'($urandom);
      a  = 13'($urandom_range(0, 15));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
      cpu_op(wr, b, a, 8'($urandom), ab, g, we, act, ga, gd);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Slot-based arbiter sharing the single 32 KB video RAM (four 8 KB colour banks) between the video fetch engine and the Z80 CPU. Each `ce` period is one memory slot. The video fetch has absolute priority on the slots it claims. The CPU is granted free slots and is stalled through `cpuWait` until its access completes. The block sits between the video generator, the CPU bus decode and the VRAM primitive.

## Interface
Parameters: none.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  slot strobe; one slot per `ce` period, period ≥ 2 clocks
- vidActive  in  1  video generator is in its active data window
- vidReq  in  1  video claims the slot that starts at this `ce`
- vidB  in  2  video bank select
- vidA  in  13  video byte address within the bank
- vidD  out  8  video read data, combinational copy of `memQ`
- cpuReq  in  1  CPU VRAM access request, level, held until `cpuWait` is low
- cpuWr  in  1  1 = write, 0 = read; sampled at grant
- cpuB  in  2  CPU bank select
- cpuA  in  13  CPU byte address
- cpuD  in  8  CPU write data
- cpuQ  out  8  CPU read data, registered
- cpuWait  out  1  CPU stall
- memA  out  15  VRAM address {bank, address}, registered
- memD  out  8  VRAM write data, registered
- memWe  out  1  VRAM write enable, one-clock pulse
- memQ  in  8  VRAM read data, valid 1 clock after `memA`
- grant  out  2  current slot owner: 00 none, 01 video, 10 CPU

## Operation
- **Slot boundary:** a clock edge with `ce`=1. All ownership decisions are made only at boundaries.
- **Owner selection at a boundary:**
  - `vidReq`=1 → video. `memA` ← {vidB, vidA}.
  - else, if the FSM is IDLE or WAIT with `cpuReq`=1 and the CPU is allowed → CPU. `memA` ← {cpuB, cpuA}, `memD` ← cpuD; `memWe` ← cpuWr.
  - else → none. `memA` holds its value.
- **FSM states:** IDLE, WAIT, ACCESS, DONE.
  - IDLE: `cpuReq`=1 with a grant at this boundary → ACCESS; `cpuReq`=1 otherwise → WAIT.
  - WAIT: grant at a boundary → ACCESS; `cpuReq`=0 → IDLE (abort, no memory cycle).
  - ACCESS: at the next boundary, `cpuQ` ← memQ (reads only; writes leave `cpuQ` unchanged) → DONE. A `cpuReq` drop during ACCESS does not cancel the access.
  - DONE: `cpuReq`=0 → IDLE; otherwise remain in DONE.
- **CPU stall:** `cpuWait` = cpuReq & (state ≠ DONE), combinational, so it is asserted in the same clock `cpuReq` rises.
- **Write enable:** `memWe` is high only during the clock that follows a CPU write grant.
- **Priority:** video has priority without exception. A `vidReq` at the same boundary as a pending CPU grant defers the CPU to a later slot.
- **Reset:** reset=0 asynchronously forces state IDLE and sets memA=0, memD=0, memWe=0, cpuQ=0, grant=00. `cpuWait` then follows cpuReq. Reset during ACCESS drops the access; a write whose `memWe` pulse has already occurred is not undone.

## Timing
- Grant to `memWe`: the boundary clock edge sets `memWe`; it is cleared at the next edge.
- CPU read latency: grant boundary to `cpuQ` valid is exactly one slot. `cpuWait` falls in the clock after the completing boundary.
- Minimum CPU access, with the slot free and `cpuReq` rising just before a boundary: 1 slot + 1 clock of `cpuWait`.
- `grant` is updated at every boundary and holds for the whole slot.
- Video: `memA` is valid from the boundary; `vidD` is valid from boundary+1 until the next boundary.

## Configuration
- `VRAM_CONTENTION_EN`:
  - **Defined:** the CPU is granted only at boundaries where vidActive=0. The CPU is stalled through the entire active display window, including idle slots, which reproduces original machine contention.
  - **Undefined:** the CPU is granted at any boundary where vidReq=0, so it interleaves with fetches in the free slots.
  - FSM, ports and latencies are identical in both builds.

## Test plan
- Idle bus, CPU write bank 2 addr 0x0155 data 0xA5 → `memA`=0x4155, `memD`=0xA5, `memWe` high for exactly 1 clock, `grant`=10, `cpuWait` low one slot + 1 clock after grant.
- Write then read the same location → `cpuQ`=0xA5 one slot after the read grant; `memWe` stays 0 throughout the read.
- `vidReq` and `cpuReq` present at the same boundary → `grant`=01, `memA`={vidB, vidA}; the CPU is granted at the first following boundary with vidReq=0.
- vidActive=1, vidReq toggling every slot: with `VRAM_CONTENTION_EN` the CPU waits until vidActive falls; without it the CPU completes in the first slot with vidReq=0.
- `cpuReq` dropped while in WAIT → IDLE, no `memWe`, `grant` stays ≠10; `cpuReq` dropped while in ACCESS → the access completes and the FSM passes through DONE.
- reset=0 asserted mid-ACCESS → all registered outputs 0 immediately and state IDLE; after release, a new request is serviced normally.
